// File: rtl/fifo_stream_out.sv
// Read-side adapter for the synchronous fifo: issues rd_en, absorbs the one-cycle
// read latency in a 2-entry buffer and presents the words as a valid/ready stream.
module fifo_stream_out #(
    parameter int data_width = 100,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [data_width-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic [cnt_width-1:0]  beat_cnt
);

    logic [data_width-1:0] head_q, head_d;
    logic [data_width-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [cnt_width-1:0]  beat_q, beat_d;
    logic                  pop;
    logic                  push;
    logic [2:0]            level;

    assign pop      = m_valid && m_ready;
    assign push     = inflight_q;
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign beat_cnt = beat_q;

    // Words held or already requested, after this cycle's pop leaves.
    assign level      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign fifo_rd_en = rst_n && !flush && !fifo_empty && (level < 3'd2);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        beat_d     = beat_q + cnt_width'(pop);
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = fifo_rd_data;
                else               tail_d = fifo_rd_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
        // A word returning in the cycle after a flush finds inflight cleared and is dropped.
        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: a queue stands in for the upstream fifo, and a scoreboard
// of requested-but-unaccepted words predicts every output once per cycle.
module tb_fifo_stream_out;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] beat_cnt;

    fifo_stream_out #(.data_width(DW), .cnt_width(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    // Upstream fifo: one-cycle read latency.
    logic [DW-1:0] fifo_mem[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_mem.size() > 0) fifo_rd_data <= fifo_mem.pop_front();
    end

    // Scoreboard entry: word and the edge at which the fifo handed it out.
    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;
    ent_t exp_q[$];
    int   edges;
    int   beats;
    int   n_chk;
    int   n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        fifo_mem.push_back(d);
    endtask

    task automatic model_clear();
        exp_q.delete();
        edges = 0;
        beats = 0;
    endtask

    // One clock cycle: drive, check against the scoreboard, advance the scoreboard
    // by the coming edge, then wait for the next falling edge.
    task automatic step(input bit rdy, input bit fl);
        bit exp_v;
        bit exp_pop;
        bit exp_rd;
        m_ready    = rdy;
        flush      = fl;
        fifo_empty = (fifo_mem.size() == 0);
        #1;
        if (!rst_n) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_cnt", beat_cnt, 0);
            model_clear();
        end else begin
            // A word read at edge e is captured at e+1 and visible after it.
            exp_v   = (exp_q.size() > 0) && (exp_q[0].e < edges);
            exp_pop = exp_v && rdy;
            exp_rd  = !fl && !fifo_empty && ((exp_q.size() - int'(exp_pop)) < 2);
            chk("m_valid", m_valid, exp_v);
            if (exp_v) chk("m_data", m_data, exp_q[0].d);
            chk("rd_en", fifo_rd_en, exp_rd);
            chk("beat_cnt", beat_cnt, beats % (1 << CW));
            if (exp_pop) begin
                void'(exp_q.pop_front());
                beats++;
            end
            if (fl) exp_q.delete();
            edges++;
            if (exp_rd) exp_q.push_back('{d: fifo_mem[0], e: edges});
        end
        @(negedge clk);
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    bit bp_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        n_chk = 0;
        n_err = 0;
        model_clear();
        @(negedge clk);

        // Reset with a non-empty fifo: nothing may be read.
        for (int i = 0; i < 10; i++) fifo_write(DW'(i));
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;

        // Streaming 0..9 with the consumer always ready.
        repeat (14) step(1'b1, 1'b0);
        chk("stream_cnt", beat_cnt, 10);

        // Backpressure with a 1,0,0,1,0,1 ready pattern.
        for (int i = 0; i < 10; i++) fifo_write(DW'(i));
        for (int i = 0; i < 36; i++) step(bp_pat[i % 6], 1'b0);

        // Interleaved write while reading.
        fifo_write(DW'(88));
        fifo_write(DW'(11));
        fifo_write(DW'(12));
        repeat (2) step(1'b1, 1'b0);
        fifo_write(DW'(33));
        repeat (6) step(1'b1, 1'b0);

        // Flush with the buffer full and words still queued upstream.
        for (int i = 5; i < 10; i++) fifo_write(DW'(i));
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0);

        // Counter wrap: 17 beats from reset reads back as 1.
        hard_reset();
        fifo_mem.delete();
        for (int i = 0; i < 17; i++) fifo_write(DW'(100 + i));
        repeat (21) step(1'b1, 1'b0);
        chk("wrap_cnt", beat_cnt, 1);

        // Randomised traffic, flushes and occasional mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            int rdy_pct;
            rdy_pct = (i < 500) ? 90 : (i < 1000) ? 40 : 70;
            if ($urandom_range(99) < 45 && fifo_mem.size() < 8) fifo_write(DW'($urandom));
            if (i % 400 == 399) begin
                hard_reset();
            end else begin
                step($urandom_range(99) < rdy_pct, $urandom_range(99) < 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
